// File: rtl/glyph_match_ctrl_if.sv
// Handshake and memory-port bundle between the glyph matcher and its image/ROM environment.
// master = the matcher itself, slave = the surrounding image buffer, glyph ROMs and requester.
interface glyph_match_ctrl_if;
    logic        start;
    logic [15:0] img_row;
    logic [15:0] rom_row;
    logic [3:0]  img_addr;
    logic [3:0]  rom_addr;
    logic [3:0]  rom_sel;
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [8:0]  score;

    modport master (
        input  start, img_row, rom_row,
        output img_addr, rom_addr, rom_sel, busy, done, digit, score
    );

    modport slave (
        output start, img_row, rom_row,
        input  img_addr, rom_addr, rom_sel, busy, done, digit, score
    );
endinterface

// File: rtl/glyph_match_ctrl.sv
// Scans a 16x16 image against NUM_GLYPHS glyph ROMs, one row per cycle, and reports
// the glyph with the highest matching-pixel count (first one wins on ties).
module glyph_match_ctrl #(
    parameter int NUM_GLYPHS = 10,
    parameter int MIN_SCORE  = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    glyph_match_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_SEL  = 4'(NUM_GLYPHS - 1);
    localparam logic [9:0] MIN_SCORE_W = 10'(MIN_SCORE);
    localparam logic [3:0] NO_MATCH  = 4'hF;

    state_t      state_reg;
    logic [3:0]  rom_addr_reg;
    logic [3:0]  rom_sel_reg;
    logic [8:0]  acc_reg;
    logic [8:0]  best_score_reg;
    logic [3:0]  best_idx_reg;
    logic [8:0]  score_reg;
    logic [3:0]  digit_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [15:0] match_bits;
    logic [4:0]  row_match;
    logic [8:0]  glyph_total;
    logic [8:0]  best_score_next;
    logic [3:0]  best_idx_next;
    logic        last_row;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match_bits[gi] = ~(bus.img_row[gi] ^ bus.rom_row[gi]);
        end
    endgenerate

    always_comb begin
        row_match = '0;
        for (int i = 0; i < 16; i++) begin
            row_match = row_match + 5'(match_bits[i]);
        end
    end

    assign glyph_total = acc_reg + {4'b0, row_match};
    assign last_row    = (rom_addr_reg == 4'd15) && (rom_sel_reg == LAST_SEL);

    // Final row of each glyph is folded in combinationally so the last glyph
    // can be judged on the same edge that leaves SCAN.
    always_comb begin
        best_score_next = best_score_reg;
        best_idx_next   = best_idx_reg;
        if ((rom_addr_reg == 4'd15) && (glyph_total > best_score_reg)) begin
            best_score_next = glyph_total;
            best_idx_next   = rom_sel_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rom_addr_reg   <= '0;
            rom_sel_reg    <= '0;
            acc_reg        <= '0;
            best_score_reg <= '0;
            best_idx_reg   <= NO_MATCH;
            score_reg      <= '0;
            digit_reg      <= NO_MATCH;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg     <= 1'b0;
                    rom_addr_reg <= '0;
                    rom_sel_reg  <= '0;
                    if (bus.start) begin
                        state_reg      <= SCAN;
                        busy_reg       <= 1'b1;
                        acc_reg        <= '0;
                        best_score_reg <= '0;
                        best_idx_reg   <= NO_MATCH;
                    end
                end
                SCAN: begin
                    rom_addr_reg   <= rom_addr_reg + 4'd1;
                    best_score_reg <= best_score_next;
                    best_idx_reg   <= best_idx_next;
                    if (rom_addr_reg == 4'd15) begin
                        acc_reg     <= '0;
                        rom_sel_reg <= rom_sel_reg + 4'd1;
                    end else begin
                        acc_reg <= glyph_total;
                    end
                    if (last_row) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        rom_sel_reg <= '0;
                        score_reg   <= best_score_next;
                        digit_reg   <= ({1'b0, best_score_next} >= MIN_SCORE_W) ? best_idx_next : NO_MATCH;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_reg;
    assign bus.img_addr = rom_addr_reg;
    assign bus.rom_sel  = rom_sel_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.digit    = digit_reg;
    assign bus.score    = score_reg;
endmodule

// File: tb/tb_glyph_match_ctrl.sv
// Directed bench: two matcher instances (default threshold and MIN_SCORE=257) run in lockstep
// on the same image buffer and glyph ROM model.
module tb_glyph_match_ctrl;
    logic clk;
    logic rst_n;
    logic start;

    logic [15:0] rom_mem [16][16];
    logic [15:0] img_mem [16];

    int errors;
    int checks;
    logic [3:0] last_digit;
    logic [8:0] last_score;
    logic [3:0] last_digit2;

    glyph_match_ctrl_if bus0 ();
    glyph_match_ctrl_if bus1 ();

    assign bus0.start   = start;
    assign bus1.start   = start;
    assign bus0.rom_row = rom_mem[bus0.rom_sel][bus0.rom_addr];
    assign bus1.rom_row = rom_mem[bus1.rom_sel][bus1.rom_addr];
    assign bus0.img_row = img_mem[bus0.img_addr];
    assign bus1.img_row = img_mem[bus1.img_addr];

    glyph_match_ctrl #(.NUM_GLYPHS(10), .MIN_SCORE(200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    glyph_match_ctrl #(.NUM_GLYPHS(10), .MIN_SCORE(257)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_image(input int g);
        for (int r = 0; r < 16; r++) img_mem[r] = rom_mem[g][r];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: busy=%b done=%b required 0/0", bus0.busy, bus0.done);
        end
        checks++;
        if (bus0.digit !== 4'hF || bus0.score !== 9'd0) begin
            errors++;
            $display("FAIL reset_result: digit=%h score=%0d required f/0", bus0.digit, bus0.score);
        end
        checks++;
        if (bus0.rom_sel !== 4'd0 || bus0.rom_addr !== 4'd0 || bus0.img_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_addr: sel=%0d addr=%0d img_addr=%0d required 0/0/0",
                     bus0.rom_sel, bus0.rom_addr, bus0.img_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_digit  = 4'hF;
        last_score  = 9'd0;
        last_digit2 = 4'hF;
        $display("reset: busy=%b done=%b digit=%h score=%0d", bus0.busy, bus0.done, bus0.digit, bus0.score);
    endtask

    // One single-cycle start; edge 1 is the edge that samples start.
    task automatic run_pass(input string name, input logic [3:0] exp_digit,
                            input logic [8:0] exp_score, input logic [3:0] exp_digit2);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        busy_cnt = (bus0.busy === 1'b1) ? 1 : 0;
        while (bus0.done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (bus0.busy === 1'b1) busy_cnt++;
            if (n == 80) begin
                checks++;
                if (bus0.rom_sel !== 4'd4 || bus0.rom_addr !== 4'd15 || bus0.img_addr !== 4'd15) begin
                    errors++;
                    $display("FAIL %s_scan_addr: sel=%0d addr=%0d img_addr=%0d required 4/15/15",
                             name, bus0.rom_sel, bus0.rom_addr, bus0.img_addr);
                end
                checks++;
                if (bus0.digit !== last_digit || bus0.score !== last_score) begin
                    errors++;
                    $display("FAIL %s_hold: digit=%h score=%0d required %h/%0d",
                             name, bus0.digit, bus0.score, last_digit, last_score);
                end
            end
        end
        checks++;
        if (n != 161) begin
            errors++;
            $display("FAIL %s_latency: done at edge %0d required 161", name, n);
        end
        checks++;
        if (busy_cnt != 161) begin
            errors++;
            $display("FAIL %s_busy_len: busy cycles %0d required 161", name, busy_cnt);
        end
        checks++;
        if (bus0.digit !== exp_digit || bus0.score !== exp_score) begin
            errors++;
            $display("FAIL %s_result: digit=%h score=%0d required %h/%0d",
                     name, bus0.digit, bus0.score, exp_digit, exp_score);
        end
        checks++;
        if (bus1.done !== 1'b1 || bus1.digit !== exp_digit2 || bus1.score !== exp_score) begin
            errors++;
            $display("FAIL %s_hi_result: done=%b digit=%h score=%0d required 1/%h/%0d",
                     name, bus1.done, bus1.digit, bus1.score, exp_digit2, exp_score);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.rom_sel !== 4'd0 || bus0.rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL %s_idle: done=%b busy=%b sel=%0d addr=%0d required 0/0/0/0",
                     name, bus0.done, bus0.busy, bus0.rom_sel, bus0.rom_addr);
        end
        last_digit  = exp_digit;
        last_score  = exp_score;
        last_digit2 = exp_digit2;
        $display("pass %s: digit=%h score=%0d hi_digit=%h latency=%0d busy=%0d",
                 name, bus0.digit, bus0.score, bus1.digit, n, busy_cnt);
    endtask

    task automatic test_exact_match();
        load_image(0);
        run_pass("glyph0", 4'd0, 9'd256, 4'hF);
    endtask

    task automatic test_noisy_match();
        load_image(7);
        img_mem[0] = img_mem[0] ^ 16'h03FF;
        run_pass("glyph7_noisy", 4'd7, 9'd246, 4'hF);
    endtask

    task automatic test_tie();
        for (int r = 0; r < 16; r++) rom_mem[5][r] = rom_mem[2][r];
        load_image(2);
        run_pass("tie_2_5", 4'd2, 9'd256, 4'hF);
    endtask

    task automatic test_threshold();
        load_image(3);
        run_pass("glyph3_thresh", 4'd3, 9'd256, 4'hF);
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int done_seen;
        load_image(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 81) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b done=%b required 0/0", bus0.busy, bus0.done);
        end
        checks++;
        if (bus0.digit !== 4'hF || bus0.score !== 9'd0 || bus0.rom_sel !== 4'd0) begin
            errors++;
            $display("FAIL abort_result: digit=%h score=%0d sel=%0d required f/0/0",
                     bus0.digit, bus0.score, bus0.rom_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus0.done === 1'b1 || bus0.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles %0d required 0", done_seen);
        end
        last_digit  = 4'hF;
        last_score  = 9'd0;
        last_digit2 = 4'hF;
        $display("abort: reset at scan edge %0d digit=%h score=%0d", n, bus0.digit, bus0.score);
        run_pass("after_abort", 4'd0, 9'd256, 4'hF);
    endtask

    task automatic test_back_to_back();
        int n;
        int pulses;
        int prev_edge;
        load_image(9);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        pulses = 0;
        prev_edge = 0;
        while (pulses < 3 && n < 700) begin
            @(posedge clk);
            #1;
            n++;
            if (bus0.done === 1'b1) begin
                pulses++;
                checks++;
                if ((pulses == 1 && n != 161) || (pulses > 1 && n - prev_edge != 162)) begin
                    errors++;
                    $display("FAIL b2b_period: pulse %0d at edge %0d previous %0d required spacing 162 (first 161)",
                             pulses, n, prev_edge);
                end
                checks++;
                if (bus0.digit !== 4'd9 || bus0.score !== 9'd256) begin
                    errors++;
                    $display("FAIL b2b_result: pulse %0d digit=%h score=%0d required 9/256",
                             pulses, bus0.digit, bus0.score);
                end
                $display("b2b pulse %0d: edge=%0d digit=%h score=%0d", pulses, n, bus0.digit, bus0.score);
                prev_edge = n;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL b2b_count: pulses %0d required 3", pulses);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b required 0", bus0.busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        for (int g = 0; g < 16; g++)
            for (int r = 0; r < 16; r++)
                rom_mem[g][r] = 16'($urandom);
        for (int r = 0; r < 16; r++) img_mem[r] = 16'h0000;

        test_reset();
        test_exact_match();
        test_noisy_match();
        test_threshold();
        test_tie();
        test_reset_mid_scan();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
